seg5461_capture: RTL and testbench



---
 rtl/seg5461_capture_if.sv | 23 ++
 rtl/seg5461_capture.sv | 187 ++++++++++++++++++
 tb/tb_seg5461_capture.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg5461_capture_if.sv
// Bus bundle for the 7-segment capture block: raw multiplexed display pins
// going in, and the rebuilt frame going out.
interface seg5461_capture_if;
  logic [7:0]  segments;     // {a,b,c,d,e,f,g,dp}, active-high
  logic [3:0]  digits;       // {D4,D3,D2,D1}, active-high
  logic [15:0] hexx;         // [3:0]=D1 ... [15:12]=D4
  logic [3:0]  points;       // dp per digit, bit0=D1
  logic [3:0]  err_digits;   // 1 = illegal glyph on that digit
  logic        frame_valid;  // one-cycle pulse on frame update
  logic        active;       // capture seen within the timeout window

  // Display side: drives the pins, observes the decoded frame.
  modport master (
    output segments, digits,
    input  hexx, points, err_digits, frame_valid, active
  );

  // Capture block side.
  modport slave (
    input  segments, digits,
    output hexx, points, err_digits, frame_valid, active
  );
endinterface

// File: rtl/seg5461_capture.sv
// Receive-side decoder for a multiplexed 4-digit common-cathode 7-segment bus.
// Synchronises the pins, waits for each digit slot to settle, decodes the glyph
// and publishes a complete 4-digit frame once every digit has been captured.
module seg5461_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_STABLE  = 4,
  parameter int TIMEOUT     = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  seg5461_capture_if.slave bus
);

  localparam int CNT_W  = $clog2(MIN_STABLE + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MIN_STABLE);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  // Synchroniser pipelines; the newest sample enters at the low end.
  logic [SYNC_STAGES*8-1:0] seg_pipe_reg;
  logic [SYNC_STAGES*4-1:0] dig_pipe_reg;
  logic [7:0]  ss;
  logic [3:0]  ds;

  // Slot tracking
  logic [11:0]       prev_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              captured_reg, captured_next;

  // Frame assembly
  logic [3:0]  seen_reg, seen_next;
  logic [15:0] stage_hex_reg;
  logic [3:0]  stage_dp_reg, stage_err_reg;
  logic [15:0] merge_hex;
  logic [3:0]  merge_dp, merge_err;

  // Outputs and activity
  logic [15:0]       hexx_reg;
  logic [3:0]        points_reg, err_reg;
  logic              frame_valid_reg;
  logic              active_reg, active_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;

  logic       one_hot, same, capture, commit, timeout_hit;
  logic [4:0] dec;

  assign ss = seg_pipe_reg[SYNC_STAGES*8-1 -: 8];
  assign ds = dig_pipe_reg[SYNC_STAGES*4-1 -: 4];

  // Exact-match glyph decode: {error, nibble}; unknown patterns give 0 + error.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      7'b1110111: r = 5'h0A;
      7'b0011111: r = 5'h0B;
      7'b1001110: r = 5'h0C;
      7'b0111101: r = 5'h0D;
      7'b1001111: r = 5'h0E;
      7'b1000111: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  assign dec = decode_glyph(ss[7:1]);

  // Staging as it would look after writing the current slot; this is what a
  // commit publishes so the outputs always see a whole frame at once.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merge_hex[gi*4 +: 4] = ds[gi] ? dec[3:0] : stage_hex_reg[gi*4 +: 4];
      assign merge_dp[gi]         = ds[gi] ? ss[0]    : stage_dp_reg[gi];
      assign merge_err[gi]        = ds[gi] ? dec[4]   : stage_err_reg[gi];
    end
  endgenerate

  // Shift the raw pins through the synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_pipe_reg <= '0;
      dig_pipe_reg <= '0;
    end else begin
      seg_pipe_reg <= {seg_pipe_reg[SYNC_STAGES*8-9:0], bus.segments};
      dig_pipe_reg <= {dig_pipe_reg[SYNC_STAGES*4-5:0], bus.digits};
    end
  end

  // Stability, capture, frame-commit and idle decisions for this cycle.
  always_comb begin
    one_hot       = (ds != 4'd0) && ((ds & (ds - 4'd1)) == 4'd0);
    same          = ({ds, ss} == prev_reg);
    cnt_next      = '0;
    captured_next = captured_reg;
    capture       = 1'b0;
    commit        = 1'b0;
    timeout_hit   = 1'b0;
    seen_next     = seen_reg;
    idle_next     = idle_reg;
    active_next   = active_reg;

    // The counter only runs while a single digit is lit and nothing moves.
    if (one_hot && same) begin
      cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
    end
    capture = one_hot && same && !captured_reg && (cnt_reg == CNT_MAX - CNT_W'(1));

    // Any change re-arms the slot; otherwise a capture latches it.
    if (!same) begin
      captured_next = 1'b0;
    end else if (capture) begin
      captured_next = 1'b1;
    end

    commit      = capture && ((seen_reg | ds) == 4'hF);
    timeout_hit = (idle_reg == IDLE_MAX) && !capture;

    if (capture) begin
      seen_next   = commit ? 4'h0 : (seen_reg | ds);
      idle_next   = '0;
      active_next = 1'b1;
    end else begin
      if (idle_reg != IDLE_MAX) begin
        idle_next = idle_reg + IDLE_W'(1);
      end
      if (timeout_hit) begin
        // A stalled bus discards partial frames but keeps the last good one.
        seen_next   = 4'h0;
        active_next = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg        <= '0;
      cnt_reg         <= '0;
      captured_reg    <= 1'b0;
      seen_reg        <= '0;
      stage_hex_reg   <= '0;
      stage_dp_reg    <= '0;
      stage_err_reg   <= '0;
      hexx_reg        <= '0;
      points_reg      <= '0;
      err_reg         <= '0;
      frame_valid_reg <= 1'b0;
      active_reg      <= 1'b0;
      idle_reg        <= '0;
    end else begin
      prev_reg        <= {ds, ss};
      cnt_reg         <= cnt_next;
      captured_reg    <= captured_next;
      seen_reg        <= seen_next;
      idle_reg        <= idle_next;
      active_reg      <= active_next;
      frame_valid_reg <= commit;
      if (capture) begin
        stage_hex_reg <= merge_hex;
        stage_dp_reg  <= merge_dp;
        stage_err_reg <= merge_err;
      end
      if (commit) begin
        hexx_reg   <= merge_hex;
        points_reg <= merge_dp;
        err_reg    <= merge_err;
      end
    end
  end

  assign bus.hexx        = hexx_reg;
  assign bus.points      = points_reg;
  assign bus.err_digits  = err_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.active      = active_reg;

endmodule

// File: tb/tb_seg5461_capture.sv
// Bench for seg5461_capture: directed test-plan scenarios followed by random
// multiplex traffic, every cycle compared against a pin-level reference model.
module tb_seg5461_capture;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_STABLE  = 4;
  localparam int TIMEOUT     = 100;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef struct packed {
    logic [15:0] hexx;
    logic [3:0]  points;
    logic [3:0]  err;
    logic        fv;
    logic        act;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg5461_capture_if bus_if();

  seg5461_capture #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_STABLE (MIN_STABLE),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int fv_seen  = 0;

  // Reference model, working on the pin samples themselves: a slot is taken
  // once the same one-hot pattern has been sampled MIN_STABLE+1 times in a row,
  // and its effect shows up at the outputs SYNC_STAGES cycles later.
  logic [11:0] m_last;
  int          m_run;
  int          m_edge = 0;
  int          m_last_cap;
  bit          m_have_cap;
  logic [3:0]  m_seen;
  logic [15:0] m_stage_hex, m_hexx;
  logic [3:0]  m_stage_dp, m_stage_err, m_pts, m_err;
  logic        m_fv;
  snap_t       hist[$];

  function automatic logic [4:0] m_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 0; i < 16; i++) begin
      if (p == GLYPH[i]) r = {1'b0, 4'(i)};
    end
    return r;
  endfunction

  task automatic model_reset();
    snap_t z;
    z = '0;
    m_last = '0; m_run = 1; m_have_cap = 0; m_last_cap = 0;
    m_seen = '0; m_stage_hex = '0; m_stage_dp = '0; m_stage_err = '0;
    m_hexx = '0; m_pts = '0; m_err = '0; m_fv = 1'b0;
    hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(z);
  endtask

  task automatic model_sample(input logic [3:0] dig, input logic [7:0] seg);
    snap_t s;
    int idx;
    logic [4:0] d;
    m_edge++;
    if ({dig, seg} == m_last) m_run++;
    else begin
      m_run  = 1;
      m_last = {dig, seg};
    end
    m_fv = 1'b0;
    if ($countones(dig) == 1 && m_run == MIN_STABLE + 1) begin
      if (m_have_cap && (m_edge - m_last_cap) > TIMEOUT + 1) m_seen = '0;
      idx = 0;
      for (int i = 0; i < 4; i++) if (dig[i]) idx = i;
      d = m_decode(seg[7:1]);
      m_stage_hex[idx*4 +: 4] = d[3:0];
      m_stage_err[idx]        = d[4];
      m_stage_dp[idx]         = seg[0];
      m_seen[idx]             = 1'b1;
      if (m_seen == 4'hF) begin
        m_hexx = m_stage_hex; m_pts = m_stage_dp; m_err = m_stage_err;
        m_fv   = 1'b1;
        m_seen = '0;
      end
      m_have_cap = 1;
      m_last_cap = m_edge;
    end
    s.hexx = m_hexx; s.points = m_pts; s.err = m_err; s.fv = m_fv;
    s.act  = m_have_cap && ((m_edge - m_last_cap) <= TIMEOUT);
    hist.push_back(s);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: drive pins (at a falling edge), let the DUT sample,
  // then compare every output against the model's delayed view.
  task automatic step(input logic [3:0] dig, input logic [7:0] seg);
    snap_t e;
    bus_if.digits   = dig;
    bus_if.segments = seg;
    @(posedge clk);
    model_sample(dig, seg);
    #1;
    e = hist.pop_front();
    chk("hexx",        32'(bus_if.hexx),        32'(e.hexx));
    chk("points",      32'(bus_if.points),      32'(e.points));
    chk("err_digits",  32'(bus_if.err_digits),  32'(e.err));
    chk("frame_valid", 32'(bus_if.frame_valid), 32'(e.fv));
    chk("active",      32'(bus_if.active),      32'(e.act));
    if (bus_if.frame_valid) begin
      fv_seen++;
      $display("frame @%0d hexx=%h points=%b err=%b active=%b",
               m_edge, bus_if.hexx, bus_if.points, bus_if.err_digits, bus_if.active);
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] dig, input logic [7:0] seg, input int len);
    for (int i = 0; i < len; i++) step(dig, seg);
  endtask

  task automatic show(input int idx, input logic [3:0] nib, input logic dp, input int len);
    hold(4'(1 << idx), {GLYPH[nib], dp}, len);
    hold(4'h0, 8'h00, 2);
  endtask

  task automatic rotation(input logic [15:0] hv, input logic [3:0] pts);
    for (int d = 0; d < 4; d++) show(d, hv[d*4 +: 4], pts[d], 20);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.digits = '0; bus_if.segments = '0;
    #1;
    chk("rst_hexx",   32'(bus_if.hexx),        32'h0);
    chk("rst_points", 32'(bus_if.points),      32'h0);
    chk("rst_err",    32'(bus_if.err_digits),  32'h0);
    chk("rst_fv",     32'(bus_if.frame_valid), 32'h0);
    chk("rst_active", 32'(bus_if.active),      32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int drop_at;
    int exp_drop;
    logic [3:0] rdig;
    logic [7:0] rseg;

    bus_if.digits = '0;
    bus_if.segments = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Loopback rotation of 0x1A2F, three full scans
    fv_seen = 0;
    for (int r = 0; r < 3; r++) rotation(16'h1A2F, 4'b0101);
    chk("t1_frames", 32'(fv_seen),           32'd3);
    chk("t1_hexx",   32'(bus_if.hexx),       32'h1A2F);
    chk("t1_points", 32'(bus_if.points),     32'h5);
    chk("t1_err",    32'(bus_if.err_digits), 32'h0);

    // Ghost filter: a 3-cycle '3' on D2 must never be taken
    fv_seen = 0;
    hold(4'b0010, {GLYPH[3], 1'b0}, 3);
    hold(4'b0010, {GLYPH[2], 1'b0}, 10);
    hold(4'h0, 8'h00, 2);
    show(0, 4'h5, 1'b0, 20);
    show(2, 4'h7, 1'b0, 20);
    show(3, 4'h8, 1'b0, 20);
    chk("t2_frames", 32'(fv_seen),     32'd1);
    chk("t2_hexx",   32'(bus_if.hexx), 32'h8725);

    // Illegal glyph on D3
    show(0, 4'h1, 1'b0, 20);
    show(1, 4'h2, 1'b0, 20);
    hold(4'b0100, {7'b1100000, 1'b0}, 20);
    hold(4'h0, 8'h00, 2);
    show(3, 4'h4, 1'b0, 20);
    chk("t3_hexx", 32'(bus_if.hexx),       32'h4021);
    chk("t3_err",  32'(bus_if.err_digits), 32'h4);

    // Multi-hot then blanking: nothing captured, still active
    fv_seen = 0;
    hold(4'b0011, {GLYPH[8], 1'b1}, 40);
    hold(4'h0, 8'h00, 40);
    chk("t4_frames", 32'(fv_seen),       32'd0);
    chk("t4_active", 32'(bus_if.active), 32'd1);

    // Timeout: active falls TIMEOUT+1 cycles after the last capture
    rotation(16'hBEEF, 4'b1111);
    exp_drop = m_last_cap + SYNC_STAGES + TIMEOUT + 1;
    drop_at = -1;
    for (int i = 0; i < 200; i++) begin
      step(4'h0, 8'h00);
      if (drop_at < 0 && !bus_if.active) drop_at = m_edge;
    end
    chk("t5_drop_cycle", 32'(drop_at),     32'(exp_drop));
    chk("t5_hold_hexx",  32'(bus_if.hexx), 32'hBEEF);
    fv_seen = 0;
    show(3, 4'hC, 1'b0, 20);
    chk("t5_partial", 32'(fv_seen), 32'd0);
    show(0, 4'h3, 1'b0, 20);
    show(1, 4'h2, 1'b0, 20);
    show(2, 4'h1, 1'b0, 20);
    chk("t5_frames", 32'(fv_seen),     32'd1);
    chk("t5_hexx",   32'(bus_if.hexx), 32'hC123);

    // Reset in the middle of a frame
    show(0, 4'h7, 1'b1, 20);
    show(1, 4'h7, 1'b1, 20);
    show(2, 4'h7, 1'b1, 20);
    do_reset();
    fv_seen = 0;
    show(3, 4'h9, 1'b1, 20);
    hold(4'h0, 8'h00, 10);
    chk("t6_frames", 32'(fv_seen),           32'd0);
    chk("t6_hexx",   32'(bus_if.hexx),       32'h0);
    chk("t6_points", 32'(bus_if.points),     32'h0);
    chk("t6_err",    32'(bus_if.err_digits), 32'h0);

    // Random multiplex traffic
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(19, 0))
        0, 1, 2:  rdig = 4'h0;
        3, 4, 5:  rdig = 4'($urandom_range(15, 0));
        default:  rdig = 4'(1 << $urandom_range(3, 0));
      endcase
      if ($urandom_range(9, 0) < 8) rseg = {GLYPH[$urandom_range(15, 0)], 1'($urandom_range(1, 0))};
      else                          rseg = 8'($urandom_range(255, 0));
      hold(rdig, rseg, $urandom_range(12, 1));
    end
    hold(4'h0, 8'h00, 150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
